// File: rtl/lcd_bitmap_writer.sv
// lcd_bitmap_writer: powers up an ST7920-class 128x64 LCD over its 8-bit
// parallel bus, then copies a 64x64 bitmap ROM row by row into graphic RAM.
// One automatic frame follows init; each start pulse in IDLE redraws.
module lcd_bitmap_writer #(
  parameter int unsigned WR_CYCLES  = 4000,
  parameter int unsigned EN_HIGH    = 1000,
  parameter int unsigned CLR_CYCLES = 100000,
  parameter int unsigned PWR_CYCLES = 2500000,
  parameter int unsigned X_WORD     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [5:0]  rom_addr,
  input  logic [63:0] rom_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_db,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_M1  = (PWR_CYCLES > CLR_CYCLES) ? PWR_CYCLES : CLR_CYCLES;
  localparam int unsigned CNT_MAX = (CNT_M1 > WR_CYCLES) ? CNT_M1 : WR_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_HIGH);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYCLES - 1);
  localparam logic [7:0]    X_OFF    = 8'(X_WORD);

  typedef enum logic [3:0] {
    S_PWR_WAIT,
    S_INIT,
    S_CLR_WAIT,
    S_LOAD,
    S_ROM_WAIT,
    S_CMD_Y,
    S_CMD_X,
    S_DATA,
    S_IDLE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [5:0]    row, row_n;
  logic [63:0]   shreg, shreg_n;
  logic [5:0]    addr_n;
  logic [7:0]    db_n;
  logic          rs_n, en_n, busy_n, done_n;
  logic          tx_end;

  assign lcd_rw = 1'b0;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h30;
      3'd1:    return 8'h0C;
      3'd2:    return 8'h01;
      3'd3:    return 8'h06;
      3'd4:    return 8'h34;
      default: return 8'h36;
    endcase
  endfunction

  function automatic logic is_tx(input state_t s);
    return (s == S_INIT) || (s == S_CMD_Y) || (s == S_CMD_X) || (s == S_DATA);
  endfunction

  function automatic logic [7:0] tx_byte(input state_t s, input logic [2:0] i,
                                         input logic [5:0] r, input logic [63:0] sh);
    case (s)
      S_INIT:  return init_cmd(i);
      S_CMD_Y: return {3'b100, r[4:0]};
      S_CMD_X: return 8'h80 | ((r[5] ? 8'd8 : 8'd0) + X_OFF);
      S_DATA:  return sh[63:56];
      default: return 8'h00;
    endcase
  endfunction

  // State, counters and registered bus outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_PWR_WAIT;
      cnt      <= '0;
      idx      <= '0;
      row      <= '0;
      shreg    <= '0;
      rom_addr <= '0;
      lcd_db   <= '0;
      lcd_rs   <= 1'b0;
      lcd_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      row      <= row_n;
      shreg    <= shreg_n;
      rom_addr <= addr_n;
      lcd_db   <= db_n;
      lcd_rs   <= rs_n;
      lcd_en   <= en_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Sequencing plus bus outputs decoded from the upcoming state/counter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    row_n   = row;
    shreg_n = shreg;
    addr_n  = rom_addr;
    db_n    = lcd_db;
    rs_n    = lcd_rs;
    tx_end  = (cnt == WR_LAST);

    case (state)
      S_PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_n = S_INIT;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_INIT: begin
        if (tx_end) begin
          cnt_n = '0;
          if (idx == 3'd2) begin
            state_n = S_CLR_WAIT;
          end else if (idx == 3'd5) begin
            state_n = S_LOAD;
            row_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_CLR_WAIT: begin
        if (cnt == CLR_LAST) begin
          state_n = S_INIT;
          idx_n   = 3'd3;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_LOAD: begin
        addr_n  = row;
        state_n = S_ROM_WAIT;
        cnt_n   = '0;
      end
      S_ROM_WAIT: begin
        if (cnt == CW'(1)) begin
          shreg_n = rom_data;
          state_n = S_CMD_Y;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_CMD_Y: begin
        if (tx_end) begin
          state_n = S_CMD_X;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_CMD_X: begin
        if (tx_end) begin
          state_n = S_DATA;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (tx_end) begin
          cnt_n   = '0;
          shreg_n = {shreg[55:0], 8'h00};
          if (idx == 3'd7) begin
            if (row == 6'd63) begin
              state_n = S_IDLE;
            end else begin
              row_n   = row + 6'd1;
              state_n = S_LOAD;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          row_n   = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_PWR_WAIT;
        cnt_n   = '0;
      end
    endcase

    // Outputs are registered from next-state values so that lcd_db/lcd_rs
    // are already valid during t=0 and lcd_en is high exactly for t=1..EN_HIGH.
    if (is_tx(state_n) && (cnt_n == '0)) begin
      db_n = tx_byte(state_n, idx_n, row_n, shreg_n);
      rs_n = (state_n == S_DATA);
    end
    en_n   = is_tx(state_n) && (cnt_n != '0) && (cnt_n <= EN_LAST);
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_DATA) && (idx_n == 3'd7) && (row_n == 6'd63) &&
             (cnt_n == WR_LAST);
  end

endmodule

// File: tb/tb_lcd_bitmap_writer.sv
// Bench for lcd_bitmap_writer: random bitmap ROM, bus monitor, and a
// frame-level reference model of the expected LCD transaction stream.
module tb_lcd_bitmap_writer;

  localparam int unsigned WR  = 8;
  localparam int unsigned ENH = 2;
  localparam int unsigned CLR = 20;
  localparam int unsigned PWR = 10;
  localparam int unsigned XW  = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  rom_addr;
  logic [63:0] rom_data;
  logic        lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_db;
  logic        busy, done;

  logic [63:0] rom [64];
  logic [7:0]  init_cmds [6];
  logic [7:0]  row18_bytes [8];

  int unsigned total = 0;
  int unsigned bad = 0;

  lcd_bitmap_writer #(
    .WR_CYCLES(WR), .EN_HIGH(ENH), .CLR_CYCLES(CLR), .PWR_CYCLES(PWR), .X_WORD(XW)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_db(lcd_db),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Registered one-cycle ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Bus monitor
  typedef struct {
    logic        rs;
    logic [7:0]  db;
    int unsigned rise;
    int unsigned hi;
    bit          stable;
  } tr_t;

  tr_t         trq[$];
  tr_t         cur;
  int unsigned pcnt = 0;
  int unsigned done_q[$];
  int unsigned busy_fall = 0;
  bit          en_q = 1'b0;
  bit          busy_q = 1'b0;

  always @(posedge clk) begin
    if (!rstn) pcnt = 0;
    else       pcnt = pcnt + 1;
  end

  always @(negedge clk) begin
    if (!rstn) begin
      en_q   = 1'b0;
      busy_q = 1'b0;
    end else begin
      if (lcd_en && !en_q) begin
        cur.rs = lcd_rs; cur.db = lcd_db; cur.rise = pcnt; cur.hi = 1; cur.stable = 1'b1;
      end else if (lcd_en) begin
        cur.hi = cur.hi + 1;
        if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 1'b0;
      end else if (en_q) begin
        if (lcd_rs !== cur.rs || lcd_db !== cur.db) cur.stable = 1'b0;
        trq.push_back(cur);
      end
      if (done) done_q.push_back(pcnt);
      if (busy_q && !busy) busy_fall = pcnt;
      en_q   = lcd_en;
      busy_q = busy;
    end
  end

  // Reference model: expected transaction list with rise-to-rise gaps
  typedef struct {
    logic        rs;
    logic [7:0]  db;
    int unsigned gap;
  } ex_t;

  ex_t expq[$];

  task automatic build_exp(input bit with_init);
    ex_t e;
    logic [63:0] w;
    expq.delete();
    if (with_init) begin
      for (int n = 0; n < 6; n++) begin
        e.rs = 1'b0;
        e.db = init_cmds[n];
        e.gap = (n == 0) ? 0 : ((n == 3) ? WR + CLR : WR);
        expq.push_back(e);
      end
    end
    for (int r = 0; r < 64; r++) begin
      e.rs = 1'b0;
      e.db = 8'(8'h80 + (r % 32));
      e.gap = (expq.size() == 0) ? 0 : WR + 3;   // LOAD + two ROM wait clocks
      expq.push_back(e);
      e.db = 8'(8'h80 + (r / 32) * 8 + XW);
      e.gap = WR;
      expq.push_back(e);
      w = rom[r];
      for (int k = 0; k < 8; k++) begin
        e.rs = 1'b1;
        e.db = 8'((w >> (56 - 8 * k)) & 64'hFF);
        e.gap = WR;
        expq.push_back(e);
      end
    end
  endtask

  task automatic chk(input string tag, input longint got, input longint expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input bit with_init);
    int unsigned n;
    build_exp(with_init);
    chk({tag, " tx count"}, trq.size(), expq.size());
    n = (trq.size() < expq.size()) ? trq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s tx%0d rs", tag, i), trq[i].rs, expq[i].rs);
      chk($sformatf("%s tx%0d db", tag, i), trq[i].db, expq[i].db);
      chk($sformatf("%s tx%0d en_len", tag, i), trq[i].hi, ENH);
      chk($sformatf("%s tx%0d stable", tag, i), trq[i].stable, 1);
      if (i > 0)
        chk($sformatf("%s tx%0d gap", tag, i), trq[i].rise - trq[i-1].rise, expq[i].gap);
    end
    chk({tag, " done pulses"}, done_q.size(), 1);
    if (done_q.size() == 1 && n > 0) begin
      chk({tag, " done timing"}, done_q[0], trq[n-1].rise + WR - 2);
      chk({tag, " busy fall"}, busy_fall, done_q[0] + 1);
    end
  endtask

  task automatic fill_rom();
    for (int r = 0; r < 64; r++) rom[r] = {$urandom, $urandom};
    rom[18] = 64'h00018FFFE0380000;
  endtask

  initial begin
    int unsigned n;
    init_cmds   = '{8'h30, 8'h0C, 8'h01, 8'h06, 8'h34, 8'h36};
    row18_bytes = '{8'h00, 8'h01, 8'h8F, 8'hFF, 8'hE0, 8'h38, 8'h00, 8'h00};
    fill_rom();

    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    chk("rst lcd_en", lcd_en, 0);
    chk("rst lcd_db", lcd_db, 0);
    chk("rst lcd_rs", lcd_rs, 0);
    chk("rst lcd_rw", lcd_rw, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rom_addr", rom_addr, 0);

    // First frame: init + 64 rows
    rstn = 1'b1;
    step();
    chk("busy after release", busy, 1);
    n = 0;
    while (done_q.size() == 0 && n < 8000) begin step(); n++; end
    repeat (4) step();
    check_frame("frame1", 1'b1);
    if (trq.size() > 0) chk("first en rise", trq[0].rise, PWR + 1);
    if (trq.size() == 646) begin
      chk("row18 Y", trq[6 + 180].db, 8'h92);
      chk("row18 X", trq[6 + 181].db, 8'h82);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("row18 b%0d", k), trq[6 + 182 + k].db, row18_bytes[k]);
        chk($sformatf("row18 rs%0d", k), trq[6 + 182 + k].rs, 1);
      end
      chk("row32 Y", trq[6 + 320].db, 8'h80);
      chk("row32 X", trq[6 + 321].db, 8'h8A);
      chk("row63 Y", trq[6 + 630].db, 8'h9F);
      chk("row63 X", trq[6 + 631].db, 8'h8A);
    end
    chk("idle busy", busy, 0);
    chk("idle en", lcd_en, 0);

    // Redraw with a mid-frame start and a start coincident with done
    fill_rom();
    trq.delete(); done_q.delete(); busy_fall = 0;
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (trq.size() < 100 && n < 2000) begin step(); n++; end
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!done && n < 8000) begin step(); n++; end
    start = 1'b1; step(); start = 1'b0;
    repeat (20) step();
    check_frame("redraw", 1'b0);
    chk("start at done ignored busy", busy, 0);
    chk("start at done ignored tx", trq.size(), 640);

    // Reset during row 5 DATA
    trq.delete(); done_q.delete();
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (trq.size() < 53 && n < 2000) begin step(); n++; end
    chk("reached row5 data", trq.size() >= 53, 1);
    if (trq.size() > 52) chk("row5 byte0 rs", trq[52].rs, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async rst lcd_en", lcd_en, 0);
    chk("async rst lcd_db", lcd_db, 0);
    chk("async rst busy", busy, 0);
    chk("async rst rom_addr", rom_addr, 0);
    repeat (3) step();
    trq.delete(); done_q.delete();
    rstn = 1'b1;
    n = 0;
    while (trq.size() < 2 && n < 200) begin step(); n++; end
    chk("restart tx seen", trq.size(), 2);
    if (trq.size() >= 2) begin
      chk("restart rise", trq[0].rise, PWR + 1);
      chk("restart db0", trq[0].db, 8'h30);
      chk("restart rs0", trq[0].rs, 0);
      chk("restart db1", trq[1].db, 8'h0C);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_bitmap_writer.md
Name: lcd_bitmap_writer

Overview:
- Downstream consumer of the 64x64 monochrome bitmap ROM (6-bit row address in, registered 64-bit row word out, 1-cycle read latency).
- Powers up and initialises an ST7920-class 128x64 graphic LCD over its 8-bit parallel bus.
- Walks all 64 ROM rows and writes each row into LCD graphic RAM, horizontally offset by X_WORD 16-bit words.
- Draws once automatically after init; redraws on each accepted start pulse.

Parameters:
WR_CYCLES, 4000, clocks per bus transaction (80 us at 50 MHz); minimum 4
EN_HIGH, 1000, clocks lcd_en is held high within a transaction; must be less than WR_CYCLES-1
CLR_CYCLES, 100000, extra clocks waited after the clear-display command (2 ms at 50 MHz)
PWR_CYCLES, 2500000, clocks waited after reset release before the first command (50 ms)
X_WORD, 2, horizontal GDRAM word offset of the image, range 0..4 (2 centres the 64-pixel image)

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  redraw request; sampled only in IDLE
rom_addr  out  6  row address to the bitmap ROM
rom_data  in  64  row pixels; bit 63 is the leftmost pixel
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied to 0 (write only)
lcd_en  out  1  LCD enable strobe
lcd_db  out  8  LCD data bus
busy  out  1  high from the first clock after reset release until the frame completes
done  out  1  one-cycle pulse when the last byte of a frame completes

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: rom_addr=0, lcd_rs=0, lcd_rw=0, lcd_en=0, lcd_db=0, busy=0, done=0. All counters and the row register clear to 0. FSM enters PWR_WAIT.
- Reset asserted mid-operation aborts immediately, with no completion of the current byte. Everything restarts from PWR_WAIT.
- Bus transaction timing, with cycle counter t from 0 to WR_CYCLES-1:
  - at t=0: lcd_db and lcd_rs are updated; lcd_en=0.
  - for t = 1..EN_HIGH: lcd_en=1.
  - otherwise: lcd_en=0.
  - lcd_db and lcd_rs hold stable for the whole transaction.
  - The next transaction starts on the clock after t=WR_CYCLES-1.
- FSM states:
  - PWR_WAIT: count PWR_CYCLES clocks, then go to INIT.
  - INIT: issue 6 commands in order: 0x30, 0x0C, 0x01, 0x06, 0x34, 0x36. After 0x01, insert CLR_CYCLES idle clocks with lcd_en=0. Then go to LOAD with row=0.
  - LOAD: rom_addr <= row. Go to ROM_WAIT.
  - ROM_WAIT: wait 2 clocks, then latch rom_data into a 64-bit shift register. Go to CMD_Y.
  - CMD_Y: command 0x80 | row[4:0]. Go to CMD_X.
  - CMD_X: command 0x80 | ((row[5] ? 8 : 0) + X_WORD). Go to DATA.
  - DATA: 8 data transactions with lcd_rs=1, sent MSB byte first (shift register [63:56], then shift left by 8). After the 8th byte:
    - if row == 63: pulse done and go to IDLE;
    - otherwise: row <= row + 1 and go to LOAD.
  - IDLE: busy=0; all bus outputs hold, lcd_en=0. On start=1: busy=1, row=0, go to LOAD (the init sequence is not repeated).
- start is ignored in every state except IDLE.
- Row counter is 6 bits. No wrap-around occurs; the frame terminates at row 63.
- A start in the same cycle that done pulses is ignored. IDLE is entered only on the following cycle.
- busy is 1 in all states except IDLE, and 0 during reset.
- Transaction counts:
  - first frame: 6 init + 64 x 10 = 646 transactions;
  - redraw: 640 transactions.

Test Plan:
Simulation parameters for all scenarios: WR_CYCLES=8, EN_HIGH=2, CLR_CYCLES=20, PWR_CYCLES=10; ROM model is a registered 1-cycle lookup.
1. Release reset, no start.
   - -> no lcd_en edges for the first 10 clocks;
   - -> then commands 30,0C,01,06,34,36 with rs=0;
   - -> exactly 20 extra idle clocks after 01;
   - -> lcd_en high exactly 2 clocks per transaction.
2. ROM row 18 = 0x00018FFFE0380000.
   - -> Y cmd 0x92, X cmd 0x82;
   - -> data bytes 00,01,8F,FF,E0,38,00,00 with rs=1.
3. Row 32 with X_WORD=2.
   - -> Y cmd 0x80, X cmd 0x8A;
   - -> row 63 gives Y 0x9F, X 0x8A.
4. Full first frame.
   - -> 646 lcd_en rising edges;
   - -> done high for exactly 1 cycle after the last byte;
   - -> busy falls the same cycle IDLE is entered.
5. Pulse start in IDLE.
   - -> exactly 640 transactions with no init commands, then done.
   - Start pulsed mid-frame -> ignored; total count unchanged.
6. Assert rstn low during row 5 DATA.
   - -> outputs reset asynchronously: lcd_en=0, lcd_db=0, busy=0;
   - -> after release, the sequence restarts from PWR_WAIT and 0x30.
